// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the architectural PC and selects sequential, jump/call,
// branch or return targets. The circular return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
    parameter int              PC_W         = 32,
    parameter int              RAS_DEPTH    = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               stall,
    input  logic [1:0]                         pc_src,
    input  logic                               is_call,
    input  logic [PC_W-1:0]                    jump_target,
    input  logic [15:0]                        branch_imm,
    input  logic                               clr_flags,
    output logic [PC_W-1:0]                    pc,
    output logic [PC_W-1:0]                    pc_plus1,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
    output logic [PC_W-1:0]                    ras_top,
    output logic                               ras_overflow,
    output logic                               ras_underflow
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    localparam logic [1:0] SRC_SEQ = 2'b00;
    localparam logic [1:0] SRC_JMP = 2'b01;
    localparam logic [1:0] SRC_BR  = 2'b10;
    localparam logic [1:0] SRC_RET = 2'b11;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] br_offset;

    assign pc       = pc_q;
    assign pc_plus1 = pc_q + PC_W'(1);
    // Sign-extend the 16-bit word offset to the full PC width; the add wraps naturally.
    assign br_offset = PC_W'($signed(branch_imm));

`ifdef PC_SEQ_RAS_EN

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;
    logic [PC_W-1:0]  ras_top_q;
    logic             ovf_q;
    logic             udf_q;
    logic             do_push;
    logic             do_pop;
    logic             ras_empty;
    logic             ras_full;
    logic [PTR_W-1:0] ptr_m1;
    logic [PTR_W-1:0] ptr_m2;
    logic [PC_W-1:0]  next_top;

    assign do_push   = !stall && (pc_src == SRC_JMP) && is_call;
    assign do_pop    = !stall && (pc_src == SRC_RET);
    assign ras_empty = (ras_cnt == '0);
    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign ptr_m1    = ras_ptr - PTR_W'(1);
    assign ptr_m2    = ras_ptr - PTR_W'(2);
    // Entry exposed after a pop: the one beneath the current top, or 0 once the stack drains.
    assign next_top  = (ras_cnt > CNT_W'(1)) ? ras_mem[ptr_m2] : '0;

    always_comb begin
        pc_d = pc_q;
        case (pc_src)
            SRC_SEQ: pc_d = pc_plus1;
            SRC_JMP: pc_d = jump_target;
            SRC_BR:  pc_d = pc_q + br_offset;
            SRC_RET: pc_d = ras_empty ? pc_plus1 : ras_top_q;
            default: pc_d = pc_plus1;
        endcase
    end

    // Storage is not reset; only entries below ras_cnt are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ras_ptr] <= pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr   <= '0;
            ras_cnt   <= '0;
            ras_top_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else if (!stall) begin
            if (clr_flags) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end
            // Later assignments below override the clear, so a same-cycle error wins.
            if (do_push) begin
                ras_ptr   <= ras_ptr + PTR_W'(1);
                ras_top_q <= pc_plus1;
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    ras_cnt <= ras_cnt + CNT_W'(1);
                end
            end else if (do_pop) begin
                if (ras_empty) begin
                    udf_q <= 1'b1;
                end else begin
                    ras_ptr   <= ptr_m1;
                    ras_cnt   <= ras_cnt - CNT_W'(1);
                    ras_top_q <= next_top;
                end
            end
        end
    end

    assign ras_count     = ras_cnt;
    assign ras_top       = ras_top_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = udf_q;

`else

    logic unused_ras_inputs;
    assign unused_ras_inputs = ^{is_call, clr_flags};

    // Without a stack, a return degenerates to sequential fetch.
    always_comb begin
        pc_d = pc_q;
        case (pc_src)
            SRC_SEQ: pc_d = pc_plus1;
            SRC_JMP: pc_d = jump_target;
            SRC_BR:  pc_d = pc_q + br_offset;
            SRC_RET: pc_d = pc_plus1;
            default: pc_d = pc_plus1;
        endcase
    end

    assign ras_count     = '0;
    assign ras_top       = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;

`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (!stall) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; RAS scenarios run when PC_SEQ_RAS_EN is defined,
// otherwise the stack-less return behaviour is checked.
module tb_pc_sequencer;

    localparam int              PC_W      = 32;
    localparam int              RAS_DEPTH = 8;
    localparam logic [PC_W-1:0] RV        = 32'h100;
    localparam int              CW        = $clog2(RAS_DEPTH + 1);

    logic            clk;
    logic            rst_n;
    logic            stall;
    logic [1:0]      pc_src;
    logic            is_call;
    logic [PC_W-1:0] jump_target;
    logic [15:0]     branch_imm;
    logic            clr_flags;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus1;
    logic [CW-1:0]   ras_count;
    logic [PC_W-1:0] ras_top;
    logic            ras_overflow;
    logic            ras_underflow;

    int total;
    int bad;

    pc_sequencer #(
        .PC_W(PC_W),
        .RAS_DEPTH(RAS_DEPTH),
        .RESET_VECTOR(RV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .pc_src(pc_src),
        .is_call(is_call),
        .jump_target(jump_target),
        .branch_imm(branch_imm),
        .clr_flags(clr_flags),
        .pc(pc),
        .pc_plus1(pc_plus1),
        .ras_count(ras_count),
        .ras_top(ras_top),
        .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge and are sampled by the next one.
    task automatic drive(input logic [1:0] src, input logic call, input logic [PC_W-1:0] tgt,
                         input logic [15:0] imm, input logic clr);
        pc_src      = src;
        is_call     = call;
        jump_target = tgt;
        branch_imm  = imm;
        clr_flags   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        stall = 1'b0;
        pc_src = 2'b00;
        is_call = 1'b0;
        jump_target = '0;
        branch_imm = '0;
        clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pc !== 32'h100) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h100); end
        total++;
        if (pc_plus1 !== 32'h101) begin bad++; $display("FAIL reset_pc_plus1: got %h want %h", pc_plus1, 32'h101); end
        total++;
        if ({ras_count, ras_top, ras_overflow, ras_underflow} !== '0) begin
            bad++; $display("FAIL reset_ras: count=%0d top=%h ovf=%b udf=%b want all 0", ras_count, ras_top, ras_overflow, ras_underflow);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(2'b00, 1'b0, '0, '0, 1'b0);
            total++;
            if (pc !== 32'h100 + i) begin bad++; $display("FAIL seq_step%0d: got %h want %h", i, pc, 32'h100 + i); end
            total++;
            if ({ras_overflow, ras_underflow} !== 2'b00) begin bad++; $display("FAIL seq_flags%0d: got %b want 00", i, {ras_overflow, ras_underflow}); end
        end
    endtask

    task automatic test_branch;
        drive(2'b01, 1'b0, 32'h20, '0, 1'b0);
        total++;
        if (pc !== 32'h20) begin bad++; $display("FAIL jump_0x20: got %h want %h", pc, 32'h20); end
        drive(2'b10, 1'b0, '0, 16'hFFFC, 1'b0);
        total++;
        if (pc !== 32'h1C) begin bad++; $display("FAIL branch_back4: got %h want %h", pc, 32'h1C); end
        drive(2'b10, 1'b0, '0, 16'h7FFF, 1'b0);
        total++;
        if (pc !== 32'h801B) begin bad++; $display("FAIL branch_fwd_max: got %h want %h", pc, 32'h801B); end
        drive(2'b01, 1'b0, 32'h2, '0, 1'b0);
        drive(2'b10, 1'b0, '0, 16'hFFFC, 1'b0);
        total++;
        if (pc !== 32'hFFFF_FFFE) begin bad++; $display("FAIL branch_wrap_down: got %h want %h", pc, 32'hFFFF_FFFE); end
        drive(2'b00, 1'b0, '0, '0, 1'b0);
        total++;
        if (pc !== 32'hFFFF_FFFF) begin bad++; $display("FAIL seq_to_max: got %h want %h", pc, 32'hFFFF_FFFF); end
        total++;
        if (pc_plus1 !== 32'h0) begin bad++; $display("FAIL pc_plus1_wrap: got %h want %h", pc_plus1, 32'h0); end
        drive(2'b00, 1'b0, '0, '0, 1'b0);
        total++;
        if (pc !== 32'h0) begin bad++; $display("FAIL seq_wrap: got %h want %h", pc, 32'h0); end
        drive(2'b01, 1'b0, 32'hFFFF_FFF0, '0, 1'b0);
        drive(2'b10, 1'b0, '0, 16'h0020, 1'b0);
        total++;
        if (pc !== 32'h10) begin bad++; $display("FAIL branch_wrap_up: got %h want %h", pc, 32'h10); end
    endtask

    task automatic test_call_return;
`ifdef PC_SEQ_RAS_EN
        drive(2'b01, 1'b0, 32'h10, '0, 1'b0);
        total++;
        if (ras_count !== CW'(0)) begin bad++; $display("FAIL plain_jump_no_push: got %0d want 0", ras_count); end
        drive(2'b01, 1'b1, 32'h80, '0, 1'b0);
        total++;
        if (pc !== 32'h80) begin bad++; $display("FAIL call_pc: got %h want %h", pc, 32'h80); end
        total++;
        if (ras_top !== 32'h11) begin bad++; $display("FAIL call_top: got %h want %h", ras_top, 32'h11); end
        total++;
        if (ras_count !== CW'(1)) begin bad++; $display("FAIL call_count: got %0d want 1", ras_count); end
        drive(2'b11, 1'b0, '0, '0, 1'b0);
        total++;
        if (pc !== 32'h11) begin bad++; $display("FAIL ret_pc: got %h want %h", pc, 32'h11); end
        total++;
        if (ras_count !== CW'(0) || ras_top !== 32'h0) begin
            bad++; $display("FAIL ret_empty: count=%0d top=%h want 0 and 0", ras_count, ras_top);
        end
        drive(2'b10, 1'b1, '0, 16'h0001, 1'b0);
        total++;
        if (pc !== 32'h12 || ras_count !== CW'(0)) begin
            bad++; $display("FAIL is_call_on_branch: pc=%h count=%0d want 12 and 0", pc, ras_count);
        end
`else
        drive(2'b01, 1'b0, 32'h40, '0, 1'b0);
        drive(2'b01, 1'b1, 32'h80, '0, 1'b0);
        total++;
        if (pc !== 32'h80) begin bad++; $display("FAIL noras_call_pc: got %h want %h", pc, 32'h80); end
        drive(2'b11, 1'b0, '0, '0, 1'b1);
        total++;
        if (pc !== 32'h81) begin bad++; $display("FAIL noras_ret_pc: got %h want %h", pc, 32'h81); end
        total++;
        if ({ras_count, ras_top, ras_overflow, ras_underflow} !== '0) begin
            bad++; $display("FAIL noras_outputs: count=%0d top=%h ovf=%b udf=%b want all 0", ras_count, ras_top, ras_overflow, ras_underflow);
        end
`endif
    endtask

    task automatic test_overflow;
        logic [PC_W-1:0] ret_addr [9];
        logic [PC_W-1:0] here;
        drive(2'b01, 1'b0, 32'h500, '0, 1'b0);
        here = 32'h500;
        for (int i = 0; i < 9; i++) begin
            ret_addr[i] = here + 32'h1;
            drive(2'b01, 1'b1, 32'h1000 + 32'(i) * 32'h10, '0, 1'b0);
            here = 32'h1000 + 32'(i) * 32'h10;
            if (i == 7) begin
                total++;
                if (ras_count !== CW'(8) || ras_overflow !== 1'b0) begin
                    bad++; $display("FAIL full_no_ovf: count=%0d ovf=%b want 8 and 0", ras_count, ras_overflow);
                end
            end
        end
        total++;
        if (ras_overflow !== 1'b1) begin bad++; $display("FAIL overflow_flag: got %b want 1", ras_overflow); end
        total++;
        if (ras_count !== CW'(8)) begin bad++; $display("FAIL overflow_count: got %0d want 8", ras_count); end
        total++;
        if (ras_top !== 32'h1071) begin bad++; $display("FAIL overflow_top: got %h want %h", ras_top, 32'h1071); end
        for (int j = 0; j < 8; j++) begin
            drive(2'b11, 1'b0, '0, '0, 1'b0);
            total++;
            if (pc !== ret_addr[8-j] || ras_count !== CW'(7 - j)) begin
                bad++; $display("FAIL lifo_pop%0d: pc=%h count=%0d want %h and %0d", j, pc, ras_count, ret_addr[8-j], 7 - j);
            end
        end
        total++;
        if (ras_top !== 32'h0 || ras_underflow !== 1'b0) begin
            bad++; $display("FAIL drained: top=%h udf=%b want 0 and 0", ras_top, ras_underflow);
        end
        drive(2'b11, 1'b0, '0, '0, 1'b0);
        total++;
        if (pc !== 32'h1002) begin bad++; $display("FAIL underflow_pc: got %h want %h", pc, 32'h1002); end
        total++;
        if (ras_underflow !== 1'b1 || ras_count !== CW'(0)) begin
            bad++; $display("FAIL underflow_flag: udf=%b count=%0d want 1 and 0", ras_underflow, ras_count);
        end
        stall = 1'b1;
        drive(2'b00, 1'b0, '0, '0, 1'b1);
        total++;
        if ({ras_overflow, ras_underflow} !== 2'b11) begin bad++; $display("FAIL clr_while_stalled: got %b want 11", {ras_overflow, ras_underflow}); end
        stall = 1'b0;
        drive(2'b00, 1'b0, '0, '0, 1'b1);
        total++;
        if ({ras_overflow, ras_underflow} !== 2'b00 || pc !== 32'h1003) begin
            bad++; $display("FAIL clr_flags: flags=%b pc=%h want 00 and 1003", {ras_overflow, ras_underflow}, pc);
        end
        drive(2'b11, 1'b0, '0, '0, 1'b1);
        total++;
        if ({ras_overflow, ras_underflow} !== 2'b01 || pc !== 32'h1004) begin
            bad++; $display("FAIL set_beats_clr: flags=%b pc=%h want 01 and 1004", {ras_overflow, ras_underflow}, pc);
        end
        drive(2'b00, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_stall;
        logic [PC_W-1:0] held;
        logic [CW-1:0]   held_cnt;
        drive(2'b01, 1'b0, 32'h300, '0, 1'b0);
        held     = 32'h300;
        held_cnt = ras_count;
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 1'b1, 32'h55, '0, 1'b0);
            total++;
            if (pc !== held || ras_count !== held_cnt) begin
                bad++; $display("FAIL stall_hold%0d: pc=%h count=%0d want %h and %0d", k, pc, ras_count, held, held_cnt);
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (pc !== RV) begin bad++; $display("FAIL async_reset: got %h want %h", pc, RV); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b00, 1'b0, '0, '0, 1'b0);
        total++;
        if (pc !== RV) begin bad++; $display("FAIL stall_after_reset: got %h want %h", pc, RV); end
        stall = 1'b0;
        drive(2'b00, 1'b0, '0, '0, 1'b0);
        total++;
        if (pc !== RV + 32'h1) begin bad++; $display("FAIL first_update: got %h want %h", pc, RV + 32'h1); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_branch();
        test_call_return();
`ifdef PC_SEQ_RAS_EN
        test_overflow();
`endif
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
